// File: rtl/cdc_pkg.sv
// Shared definitions for the handshake receiver: FSM states and default sizes.
package cdc_pkg;

    localparam int DATA_W_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACKING  = 2'd1,
        RELEASE = 2'd2
    } hs_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; only the last stage is safe to use.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination side of a 4-phase REQ/ACK handshake with a one-word output slot.
//
// state   | meaning
// IDLE    | waiting for a synchronized request and a free output slot
// ACKING  | word captured, ACK high until the request drops
// RELEASE | ACK low for one cycle before a new capture may happen
module cdc_hs_rx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic [DATA_W-1:0] IDATA,
    output logic              ACK,
    output logic [DATA_W-1:0] ODATA,
    output logic              OVALID,
    input  logic              OREADY
);

    hs_state_t state;
    logic      req_s;
    logic      slot_free;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (REQ),
        .q   (req_s)
    );

    // The slot can take a new word if it is empty or is being drained this cycle.
    assign slot_free = !OVALID || OREADY;

    // Handshake FSM with registered ACK and output slot; IDATA is read only on the capture edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            ACK    <= 1'b0;
            ODATA  <= '0;
            OVALID <= 1'b0;
        end else begin
            if (OVALID && OREADY) begin
                OVALID <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req_s && slot_free) begin
                        state  <= ACKING;
                        ACK    <= 1'b1;
                        ODATA  <= IDATA;
                        OVALID <= 1'b1;
                    end
                end
                ACKING: begin
                    if (!req_s) begin
                        state <= RELEASE;
                        ACK   <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ACK   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Self-checking bench for cdc_hs_rx: directed handshake scenarios plus randomized traffic
// scored against a queue of words the sender model has handed over.
`timescale 1ns/1ps
module tb_cdc_hs_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ = 1'b0;
    logic [3:0] IDATA = 4'h0;
    logic       OREADY = 1'b1;
    logic       ACK, OVALID;
    logic [3:0] ODATA;
    logic       ACK3, OVALID3;
    logic [3:0] ODATA3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    cdc_hs_rx #(.DATA_W(4), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .IDATA(IDATA),
        .ACK(ACK), .ODATA(ODATA), .OVALID(OVALID), .OREADY(OREADY)
    );

    cdc_hs_rx #(.DATA_W(4), .SYNC_STAGES(3)) dut3 (
        .CLK(CLK), .RST(RST), .REQ(REQ), .IDATA(IDATA),
        .ACK(ACK3), .ODATA(ODATA3), .OVALID(OVALID3), .OREADY(OREADY)
    );

    // Advance one edge and land on the sample/drive point just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = 1'b0;
        OREADY = 1'b1;
        IDATA = 4'h0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        total++;
        if ({ACK, OVALID, ODATA} !== 6'b0) begin
            bad++;
            $display("FAIL reset_state: got ack=%b ovalid=%b odata=%h want 0 0 0", ACK, OVALID, ODATA);
        end
        total++;
        if ({ACK3, OVALID3, ODATA3} !== 6'b0) begin
            bad++;
            $display("FAIL reset_state3: got ack=%b ovalid=%b odata=%h want 0 0 0", ACK3, OVALID3, ODATA3);
        end
        do_reset();
    endtask

    task automatic test_latency();
        do_reset();
        OREADY = 1'b1;
        IDATA = 4'hA;
        REQ = 1'b1;
        tick();
        total++;
        if ({ACK, OVALID} !== 2'b00) begin
            bad++;
            $display("FAIL lat_edge0: got ack=%b ovalid=%b want 0 0", ACK, OVALID);
        end
        tick();
        total++;
        if ({ACK, OVALID} !== 2'b00) begin
            bad++;
            $display("FAIL lat_edge1: got ack=%b ovalid=%b want 0 0", ACK, OVALID);
        end
        tick();
        total++;
        if ({ACK, OVALID, ODATA} !== {2'b11, 4'hA}) begin
            bad++;
            $display("FAIL lat_edge2: got ack=%b ovalid=%b odata=%h want 1 1 a", ACK, OVALID, ODATA);
        end
        tick();
        total++;
        if ({ACK, OVALID} !== 2'b10) begin
            bad++;
            $display("FAIL lat_consume: got ack=%b ovalid=%b want 1 0", ACK, OVALID);
        end
        repeat (3) tick();
        REQ = 1'b0;
        IDATA = 4'h6;
        tick();
        total++;
        if (ACK !== 1'b1) begin
            bad++;
            $display("FAIL lat_fall1: got ack=%b want 1", ACK);
        end
        tick();
        total++;
        if (ACK !== 1'b1) begin
            bad++;
            $display("FAIL lat_fall2: got ack=%b want 1", ACK);
        end
        tick();
        total++;
        if ({ACK, OVALID, ODATA} !== {2'b00, 4'hA}) begin
            bad++;
            $display("FAIL lat_fall3: got ack=%b ovalid=%b odata=%h want 0 0 a", ACK, OVALID, ODATA);
        end
        repeat (2) tick();
    endtask

    // Sender does full 4-phase handshakes; consumer drains with OREADY asserted ready_pct % of cycles.
    task automatic run_traffic(input int n, input bit seq, input int ready_pct);
        logic [3:0] exp_q[$];
        logic [3:0] cur = 4'h0;
        logic [3:0] exp;
        int sent = 0;
        int got = 0;
        int phase = 0;
        int gap = 0;
        int cyc = 0;
        REQ = 1'b0;
        while (got < n && cyc < 4000) begin
            case (phase)
                0: begin
                    if (sent < n) begin
                        if (gap > 0) begin
                            gap--;
                            IDATA = 4'($urandom_range(0, 15));
                        end else begin
                            cur = seq ? 4'(sent) : 4'($urandom_range(0, 15));
                            IDATA = cur;
                            REQ = 1'b1;
                            phase = 1;
                        end
                    end
                end
                1: begin
                    if (ACK) begin
                        exp_q.push_back(cur);
                        sent++;
                        REQ = 1'b0;
                        phase = 2;
                    end
                end
                default: begin
                    if (!ACK) begin
                        phase = 0;
                        gap = $urandom_range(0, 3);
                        IDATA = 4'($urandom_range(0, 15));
                    end
                end
            endcase
            OREADY = ($urandom_range(0, 99) < ready_pct);
            if (OVALID && OREADY) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL traffic_dup: got odata=%h with no word outstanding, want none", ODATA);
                end else begin
                    exp = exp_q.pop_front();
                    if (ODATA !== exp) begin
                        bad++;
                        $display("FAIL traffic_data: got %h want %h (word %0d)", ODATA, exp, got);
                    end
                    got++;
                end
            end
            tick();
            cyc++;
        end
        total++;
        if (got != n) begin
            bad++;
            $display("FAIL traffic_count: got %0d words want %0d", got, n);
        end
        OREADY = 1'b1;
        cyc = 0;
        while (ACK && cyc < 20) begin
            tick();
            cyc++;
        end
        repeat (6) tick();
        total++;
        if (OVALID !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL traffic_drain: got ovalid=%b left=%0d want 0 0", OVALID, exp_q.size());
        end
    endtask

    task automatic test_sweep();
        do_reset();
        run_traffic(16, 1'b1, 100);
    endtask

    task automatic test_random_traffic();
        do_reset();
        run_traffic(40, 1'b0, 40);
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        OREADY = 1'b0;
        IDATA = 4'h3;
        REQ = 1'b1;
        n = 0;
        while (ACK !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if ({ACK, OVALID, ODATA} !== {2'b11, 4'h3}) begin
            bad++;
            $display("FAIL bp_first: got ack=%b ovalid=%b odata=%h want 1 1 3", ACK, OVALID, ODATA);
        end
        REQ = 1'b0;
        IDATA = 4'hE;
        n = 0;
        while (ACK !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        tick();
        IDATA = 4'h5;
        REQ = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if ({ACK, OVALID, ODATA} !== {2'b01, 4'h3}) begin
                bad++;
                $display("FAIL bp_hold%0d: got ack=%b ovalid=%b odata=%h want 0 1 3", i, ACK, OVALID, ODATA);
            end
        end
        OREADY = 1'b1;
        tick();
        OREADY = 1'b0;
        total++;
        if ({ACK, OVALID, ODATA} !== {2'b11, 4'h5}) begin
            bad++;
            $display("FAIL bp_release: got ack=%b ovalid=%b odata=%h want 1 1 5", ACK, OVALID, ODATA);
        end
        REQ = 1'b0;
        n = 0;
        while (ACK !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        OREADY = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_held_req();
        logic [3:0] cur;
        logic prev_ack = 1'b0;
        int caps = 0;
        int rises = 0;
        int drops = 0;
        do_reset();
        OREADY = 1'b1;
        cur = 4'($urandom_range(0, 15));
        IDATA = cur;
        REQ = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (OVALID) begin
                caps++;
                total++;
                if (ODATA !== cur) begin
                    bad++;
                    $display("FAIL held_data: got %h want %h", ODATA, cur);
                end
            end
            if (ACK && !prev_ack) rises++;
            if (!ACK && prev_ack) drops++;
            prev_ack = ACK;
        end
        total++;
        if (caps != 1 || rises != 1 || drops != 0 || ACK !== 1'b1) begin
            bad++;
            $display("FAIL held_once: got caps=%0d rises=%0d drops=%0d ack=%b want 1 1 0 1",
                     caps, rises, drops, ACK);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        REQ = 1'b0;
        n = 0;
        while (ACK !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        tick();
        OREADY = 1'b0;
        IDATA = 4'hC;
        REQ = 1'b1;
        n = 0;
        while (ACK !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        total++;
        if ({ACK, OVALID, ODATA} !== {2'b11, 4'hC}) begin
            bad++;
            $display("FAIL rmid_pre: got ack=%b ovalid=%b odata=%h want 1 1 c", ACK, OVALID, ODATA);
        end
        #2;
        RST = 1'b1;
        #1;
        total++;
        if ({ACK, OVALID, ODATA} !== 6'b0) begin
            bad++;
            $display("FAIL rmid_async: got ack=%b ovalid=%b odata=%h want 0 0 0", ACK, OVALID, ODATA);
        end
        tick();
        tick();
        RST = 1'b0;
        tick();
        tick();
        total++;
        if ({ACK, OVALID} !== 2'b00) begin
            bad++;
            $display("FAIL rmid_early: got ack=%b ovalid=%b want 0 0", ACK, OVALID);
        end
        tick();
        total++;
        if ({ACK, OVALID, ODATA} !== {2'b11, 4'hC}) begin
            bad++;
            $display("FAIL rmid_recap: got ack=%b ovalid=%b odata=%h want 1 1 c", ACK, OVALID, ODATA);
        end
        REQ = 1'b0;
        OREADY = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_sync3();
        do_reset();
        OREADY = 1'b1;
        IDATA = 4'h9;
        REQ = 1'b1;
        tick();
        tick();
        tick();
        total++;
        if ({ACK3, OVALID3} !== 2'b00) begin
            bad++;
            $display("FAIL s3_edge2: got ack=%b ovalid=%b want 0 0", ACK3, OVALID3);
        end
        tick();
        total++;
        if ({ACK3, OVALID3, ODATA3} !== {2'b11, 4'h9}) begin
            bad++;
            $display("FAIL s3_edge3: got ack=%b ovalid=%b odata=%h want 1 1 9", ACK3, OVALID3, ODATA3);
        end
        REQ = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_backpressure();
        test_held_req();
        test_reset_mid();
        test_sync3();
        test_random_traffic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
